// File: rtl/bp_be_fe_cmd_issue.sv
// FE command issue queue: ordered buffer of BE-generated fe_cmd packets with a
// valid/yumi output, best-effort attaboys and a saturating attaboy-drop counter.

package bp_be_fe_cmd_issue_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg = 2'd0
    } bp_params_e;

    localparam int vaddr_width_gp   = 39;
    localparam int operand_width_gp = 32;

    typedef enum logic [2:0] {
        e_op_state_reset          = 3'd0,
        e_op_pc_redirection       = 3'd1,
        e_op_icache_fill_response = 3'd2,
        e_op_icache_fence         = 3'd3,
        e_op_attaboy              = 3'd4,
        e_op_wait                 = 3'd5
    } bp_fe_command_queue_opcodes_e;

    typedef struct packed {
        bp_fe_command_queue_opcodes_e opcode;
        logic [vaddr_width_gp-1:0]    vaddr;
        logic [operand_width_gp-1:0]  operands;
    } bp_fe_cmd_s;

    function automatic int fe_cmd_width(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: fe_cmd_width = $bits(bp_fe_cmd_s);
            default:          fe_cmd_width = $bits(bp_fe_cmd_s);
        endcase
    endfunction

endpackage

module bp_be_fe_cmd_issue
    import bp_be_fe_cmd_issue_pkg::*;
#(
    parameter bp_params_e bp_params_p      = e_bp_default_cfg,
    parameter int         fifo_els_p       = 4,
    parameter int         drop_cnt_width_p = 16,
    localparam int        fe_cmd_width_lp  = fe_cmd_width(bp_params_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,

    input  logic [fe_cmd_width_lp-1:0]  cmd_i,
    input  logic                        cmd_v_i,
    output logic                        cmd_ready_and_o,

    output logic [fe_cmd_width_lp-1:0]  fe_cmd_o,
    output logic                        fe_cmd_v_o,
    input  logic                        fe_cmd_yumi_i,

    output logic                        busy_o,
    output logic                        empty_o,
    output logic [drop_cnt_width_p-1:0] drop_cnt_o
);

    localparam int ptr_w_lp = $clog2(fifo_els_p);
    localparam int cnt_w_lp = ptr_w_lp + 1;
    localparam int op_w_lp  = $bits(bp_fe_command_queue_opcodes_e);
    localparam int sum_w_lp = ((drop_cnt_width_p > cnt_w_lp) ? drop_cnt_width_p : cnt_w_lp) + 1;

    typedef enum logic {
        e_init = 1'b0,
        e_run  = 1'b1
    } state_e;

    state_e                      state_q, state_d;
    logic [fe_cmd_width_lp-1:0]  mem_q [fifo_els_p];
    logic [fifo_els_p-1:0]       live_q, live_d;
    logic [ptr_w_lp:0]           wptr_q, wptr_d;
    logic [ptr_w_lp:0]           rptr_q, rptr_d;
    logic [cnt_w_lp-1:0]         nonattaboy_cnt_q, nonattaboy_cnt_d;
    logic [drop_cnt_width_p-1:0] drop_cnt_q, drop_cnt_d;

    logic [op_w_lp-1:0]  cmd_op;
    logic                cmd_is_attaboy, cmd_is_redirect, cmd_is_sreset;
    logic                full, empty;
    logic [ptr_w_lp-1:0] head_idx, tail_idx;
    logic                head_v, head_is_attaboy;
    logic                ready;
    logic                enq_fire, enq_write, enq_drop, squash_req;
    logic                yumi_pop, dead_pop, pop;
    logic                cnt_inc, cnt_dec;
    logic [fifo_els_p-1:0] entry_is_attaboy;
    logic [fifo_els_p-1:0] squash_mask;
    logic [cnt_w_lp-1:0]   squash_cnt;
    logic [sum_w_lp-1:0]   drop_sum;

    assign cmd_op          = cmd_i[fe_cmd_width_lp-1 -: op_w_lp];
    assign cmd_is_attaboy  = (cmd_op == e_op_attaboy);
    assign cmd_is_redirect = (cmd_op == e_op_pc_redirection);
    assign cmd_is_sreset   = (cmd_op == e_op_state_reset);

    // Extra wrap bit distinguishes full from empty when the indices coincide.
    assign full     = ((wptr_q ^ rptr_q) == {1'b1, {ptr_w_lp{1'b0}}});
    assign empty    = (wptr_q == rptr_q);
    assign head_idx = rptr_q[ptr_w_lp-1:0];
    assign tail_idx = wptr_q[ptr_w_lp-1:0];

    always_comb begin
        entry_is_attaboy = '0;
        for (int i = 0; i < fifo_els_p; i++) begin
            entry_is_attaboy[i] = (mem_q[i][fe_cmd_width_lp-1 -: op_w_lp] == e_op_attaboy);
        end
    end

    assign head_is_attaboy = entry_is_attaboy[head_idx];
    assign head_v          = ~empty & live_q[head_idx];

    // Until the first state_reset only that opcode may enter; others wait upstream.
    always_comb begin
        ready = 1'b0;
        case (state_q)
            e_init:  ready = cmd_is_sreset & ~full;
            e_run:   ready = cmd_is_attaboy | ~full;
            default: ready = 1'b0;
        endcase
        ready = ready & ~reset_i;
    end

    assign enq_fire   = cmd_v_i & ready;
    assign enq_write  = enq_fire & ~(cmd_is_attaboy & full);
    assign enq_drop   = enq_fire & cmd_is_attaboy & full;
    assign squash_req = enq_fire & (cmd_is_redirect | cmd_is_sreset);

    assign yumi_pop = fe_cmd_yumi_i & head_v;
    assign dead_pop = ~empty & ~live_q[head_idx];
    assign pop      = yumi_pop | dead_pop;

    // A head already presented to the FE must not change under it, so it is spared.
    always_comb begin
        squash_mask = '0;
        squash_cnt  = '0;
        for (int i = 0; i < fifo_els_p; i++) begin
            squash_mask[i] = squash_req & live_q[i] & entry_is_attaboy[i]
                           & ~(head_v & (head_idx == ptr_w_lp'(i)));
            squash_cnt     = squash_cnt + cnt_w_lp'(squash_mask[i]);
        end
    end

    always_comb begin
        live_d = live_q & ~squash_mask;
        if (pop) begin
            live_d[head_idx] = 1'b0;
        end
        if (enq_write) begin
            live_d[tail_idx] = 1'b1;
        end
    end

    assign wptr_d = wptr_q + (ptr_w_lp + 1)'(enq_write);
    assign rptr_d = rptr_q + (ptr_w_lp + 1)'(pop);

    assign cnt_inc = enq_write & ~cmd_is_attaboy;
    assign cnt_dec = yumi_pop & ~head_is_attaboy;

    always_comb begin
        nonattaboy_cnt_d = nonattaboy_cnt_q;
        case ({cnt_inc, cnt_dec})
            2'b10:   nonattaboy_cnt_d = nonattaboy_cnt_q + cnt_w_lp'(1);
            2'b01:   nonattaboy_cnt_d = nonattaboy_cnt_q - cnt_w_lp'(1);
            default: nonattaboy_cnt_d = nonattaboy_cnt_q;
        endcase
    end

    assign drop_sum = sum_w_lp'(drop_cnt_q) + sum_w_lp'(squash_cnt) + sum_w_lp'(enq_drop);

    always_comb begin
        if (drop_sum[sum_w_lp-1:drop_cnt_width_p] != '0) begin
            drop_cnt_d = '1;
        end else begin
            drop_cnt_d = drop_sum[drop_cnt_width_p-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        if (enq_fire & cmd_is_sreset) begin
            state_d = e_run;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q          <= e_init;
            live_q           <= '0;
            wptr_q           <= '0;
            rptr_q           <= '0;
            nonattaboy_cnt_q <= '0;
            drop_cnt_q       <= '0;
        end else begin
            state_q          <= state_d;
            live_q           <= live_d;
            wptr_q           <= wptr_d;
            rptr_q           <= rptr_d;
            nonattaboy_cnt_q <= nonattaboy_cnt_d;
            drop_cnt_q       <= drop_cnt_d;
        end
    end

    // Payload storage needs no reset: the output is gated by the live head.
    always_ff @(posedge clk_i) begin
        if (enq_write) begin
            mem_q[tail_idx] <= cmd_i;
        end
    end

    assign cmd_ready_and_o = ready;
    assign fe_cmd_v_o      = head_v;
    assign fe_cmd_o        = head_v ? mem_q[head_idx] : '0;
    assign busy_o          = (nonattaboy_cnt_q != '0);
    assign empty_o         = ~|live_q;
    assign drop_cnt_o      = drop_cnt_q;

`ifndef SYNTHESIS
    yumi_only_when_valid: assert property (
        @(posedge clk_i) disable iff (reset_i) fe_cmd_yumi_i |-> fe_cmd_v_o
    );
`endif

endmodule

// File: tb/tb_bp_be_fe_cmd_issue.sv
// Directed bench for bp_be_fe_cmd_issue: expected FE commands go into a queue,
// a negedge monitor pops and compares on every valid/yumi handshake.

module tb_bp_be_fe_cmd_issue;
    import bp_be_fe_cmd_issue_pkg::*;

    localparam int W  = $bits(bp_fe_cmd_s);
    localparam int DW = 2;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [W-1:0]  cmd_i = '0;
    logic          cmd_v_i = 1'b0;
    logic          cmd_ready_and_o;
    logic [W-1:0]  fe_cmd_o;
    logic          fe_cmd_v_o;
    logic          fe_cmd_yumi_i;
    logic          busy_o;
    logic          empty_o;
    logic [DW-1:0] drop_cnt_o;

    // FE model: consumes whenever enabled and a command is presented.
    bit yumi_en = 1'b0;
    assign fe_cmd_yumi_i = yumi_en & fe_cmd_v_o;

    always #5 clk = ~clk;

    bp_be_fe_cmd_issue #(
        .bp_params_p      (e_bp_default_cfg),
        .fifo_els_p       (4),
        .drop_cnt_width_p (DW)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .cmd_i           (cmd_i),
        .cmd_v_i         (cmd_v_i),
        .cmd_ready_and_o (cmd_ready_and_o),
        .fe_cmd_o        (fe_cmd_o),
        .fe_cmd_v_o      (fe_cmd_v_o),
        .fe_cmd_yumi_i   (fe_cmd_yumi_i),
        .busy_o          (busy_o),
        .empty_o         (empty_o),
        .drop_cnt_o      (drop_cnt_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mk(input bp_fe_command_queue_opcodes_e op, input int v);
        bp_fe_cmd_s c;
        c.opcode   = op;
        c.vaddr    = 39'(v);
        c.operands = 32'(v) ^ 32'h5a5a_0000;
        return c;
    endfunction

    // Monitor: handshake comparison plus stability of a presented command.
    bit           held = 1'b0;
    logic [W-1:0] held_cmd = '0;
    always @(negedge clk) begin
        if (reset_i) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("stable_valid", fe_cmd_v_o, 1);
                check("stable_cmd", fe_cmd_o, held_cmd);
            end
            if (fe_cmd_v_o && fe_cmd_yumi_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL issue_unexpected: got %0h expected none", fe_cmd_o);
                end else begin
                    check("issue", fe_cmd_o, exp_q.pop_front());
                end
            end
            held     = fe_cmd_v_o && !fe_cmd_yumi_i;
            held_cmd = fe_cmd_o;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] c, input bit expect_issue);
        bit ok = 1'b0;
        cmd_i   = c;
        cmd_v_i = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (cmd_ready_and_o) begin
                ok = 1'b1;
                if (expect_issue) exp_q.push_back(c);
            end
            cycle();
        end
        cmd_v_i = 1'b0;
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got ready=0 expected ready=1 for %0h", c);
        end
    endtask

    task automatic hold_reject(input logic [W-1:0] c, input int n, input string name);
        cmd_i   = c;
        cmd_v_i = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check(name, cmd_ready_and_o, 0);
            cycle();
        end
        cmd_v_i = 1'b0;
    endtask

    // Enqueue and consume in the same cycle.
    task automatic both(input logic [W-1:0] c, input bit expect_issue);
        cmd_i   = c;
        cmd_v_i = 1'b1;
        yumi_en = 1'b1;
        @(negedge clk);
        check("both_ready", cmd_ready_and_o, 1);
        check("both_valid", fe_cmd_v_o, 1);
        if (expect_issue) exp_q.push_back(c);
        cycle();
        cmd_v_i = 1'b0;
        yumi_en = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        yumi_en = 1'b1;
        for (int k = 0; k < max_cycles && exp_q.size() != 0; k++) cycle();
        yumi_en = 1'b0;
        check("drain_done", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        cmd_v_i = 1'b0;
        yumi_en = 1'b0;
        cmd_i   = mk(e_op_state_reset, 0);
        #2;
        reset_i = 1'b1;
        #1;
        check("rst_valid", fe_cmd_v_o, 0);
        check("rst_ready", cmd_ready_and_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_empty", empty_o, 1);
        check("rst_drop", drop_cnt_o, 0);
        check("rst_cmd", fe_cmd_o, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
    endtask

    task automatic init_run();
        do_reset();
        send(mk(e_op_state_reset, 16'h0fee), 1'b1);
        drain(10);
        check("init_empty", empty_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) cycle();

        // Test 1: only state_reset is accepted in e_init; 1-cycle latency.
        do_reset();
        hold_reject(mk(e_op_pc_redirection, 32'h100), 3, "t1_init_redirect");
        hold_reject(mk(e_op_attaboy, 32'h101), 1, "t1_init_attaboy");
        cmd_i   = mk(e_op_state_reset, 32'h200);
        cmd_v_i = 1'b1;
        @(negedge clk);
        check("t1_sreset_ready", cmd_ready_and_o, 1);
        check("t1_no_bypass", fe_cmd_v_o, 0);
        exp_q.push_back(cmd_i);
        cycle();
        cmd_v_i = 1'b0;
        check("t1_valid_next", fe_cmd_v_o, 1);
        check("t1_cmd_next", fe_cmd_o, mk(e_op_state_reset, 32'h200));
        check("t1_busy", busy_o, 1);
        check("t1_not_empty", empty_o, 0);
        drain(10);
        check("t1_busy_after", busy_o, 0);
        check("t1_empty_after", empty_o, 1);

        // Test 2: fill with attaboys, drop when full, redirect waits for a pop.
        send(mk(e_op_attaboy, 32'h301), 1'b1);
        send(mk(e_op_attaboy, 32'h302), 1'b1);
        send(mk(e_op_attaboy, 32'h303), 1'b0);
        send(mk(e_op_attaboy, 32'h304), 1'b0);
        check("t2_busy_atb", busy_o, 0);
        hold_reject(mk(e_op_pc_redirection, 32'h3f0), 2, "t2_full_redirect");
        check("t2_drop0", drop_cnt_o, 0);
        send(mk(e_op_attaboy, 32'h305), 1'b0);
        check("t2_drop1", drop_cnt_o, 1);
        cmd_i   = mk(e_op_pc_redirection, 32'h3f0);
        cmd_v_i = 1'b1;
        yumi_en = 1'b1;
        @(negedge clk);
        check("t2_full_during_pop", cmd_ready_and_o, 0);
        cycle();
        yumi_en = 1'b0;
        @(negedge clk);
        check("t2_ready_after_pop", cmd_ready_and_o, 1);
        exp_q.push_back(cmd_i);
        cycle();
        cmd_v_i = 1'b0;
        check("t2_drop_squash", drop_cnt_o, 3);
        check("t2_head_kept", fe_cmd_o, mk(e_op_attaboy, 32'h302));
        check("t2_busy", busy_o, 1);
        drain(20);
        check("t2_empty", empty_o, 1);
        check("t2_busy_end", busy_o, 0);

        // Test 3: state_reset in e_run squashes non-head attaboys, stays in e_run.
        init_run();
        send(mk(e_op_attaboy, 32'h401), 1'b1);
        send(mk(e_op_attaboy, 32'h402), 1'b0);
        send(mk(e_op_attaboy, 32'h403), 1'b0);
        send(mk(e_op_state_reset, 32'h4f0), 1'b1);
        check("t3_drop", drop_cnt_o, 2);
        check("t3_head", fe_cmd_o, mk(e_op_attaboy, 32'h401));
        check("t3_busy", busy_o, 1);
        cmd_i = mk(e_op_attaboy, 32'h404);
        #1;
        check("t3_still_run", cmd_ready_and_o, 1);
        drain(20);
        check("t3_empty", empty_o, 1);
        check("t3_drop_end", drop_cnt_o, 2);

        // Test 4: simultaneous enqueue and pop.
        init_run();
        send(mk(e_op_icache_fence, 32'h501), 1'b1);
        check("t4_busy1", busy_o, 1);
        both(mk(e_op_icache_fill_response, 32'h502), 1'b1);
        check("t4_cmd_a", fe_cmd_o, mk(e_op_icache_fill_response, 32'h502));
        check("t4_busy_a", busy_o, 1);
        check("t4_empty_a", empty_o, 0);
        both(mk(e_op_attaboy, 32'h503), 1'b1);
        check("t4_cmd_b", fe_cmd_o, mk(e_op_attaboy, 32'h503));
        check("t4_busy_b", busy_o, 0);
        check("t4_empty_b", empty_o, 0);
        both(mk(e_op_pc_redirection, 32'h504), 1'b1);
        check("t4_cmd_c", fe_cmd_o, mk(e_op_pc_redirection, 32'h504));
        check("t4_busy_c", busy_o, 1);
        check("t4_drop_c", drop_cnt_o, 0);
        drain(10);
        check("t4_empty_end", empty_o, 1);
        check("t4_busy_end", busy_o, 0);

        // Test 5: drop counter saturates at 3 with a 2-bit counter.
        init_run();
        for (int k = 1; k <= 4; k++) send(mk(e_op_attaboy, 32'h600 + k), 1'b1);
        for (int k = 1; k <= 5; k++) begin
            send(mk(e_op_attaboy, 32'h610 + k), 1'b0);
            check("t5_drop", drop_cnt_o, (k > 3) ? 3 : k);
        end
        drain(20);
        check("t5_empty", empty_o, 1);
        check("t5_drop_end", drop_cnt_o, 3);

        // Test 6: asynchronous reset with non-attaboys buffered.
        init_run();
        send(mk(e_op_icache_fence, 32'h701), 1'b0);
        send(mk(e_op_icache_fill_response, 32'h702), 1'b0);
        send(mk(e_op_pc_redirection, 32'h703), 1'b0);
        check("t6_valid_pre", fe_cmd_v_o, 1);
        check("t6_busy_pre", busy_o, 1);
        check("t6_cmd_pre", fe_cmd_o, mk(e_op_icache_fence, 32'h701));
        do_reset();
        for (int k = 0; k < 3; k++) begin
            check("t6_no_valid", fe_cmd_v_o, 0);
            cycle();
        end
        hold_reject(mk(e_op_pc_redirection, 32'h710), 2, "t6_init_redirect");
        send(mk(e_op_state_reset, 32'h720), 1'b1);
        check("t6_valid_sreset", fe_cmd_v_o, 1);
        drain(10);
        check("t6_empty_end", empty_o, 1);

        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
